// File: rtl/spi_slave_tx_feeder.sv
// Feeds 32-bit words from a read-data FIFO into the SPI slave transmit shifter.
// After a read command and a programmable dummy delay, the words go out back-to-back.
module spi_slave_tx_feeder #(
    parameter int          LEN_W         = 16,
    parameter int          DUMMY_W       = 8,
    parameter logic [31:0] UNDERRUN_WORD = 32'hDEAD_BEEF
) (
    input  logic               sclk,
    input  logic               cs,
    input  logic               rd_start_i,
    input  logic [LEN_W-1:0]   rd_len_i,
    input  logic [DUMMY_W-1:0] dummy_cycles_i,
    input  logic [31:0]        fifo_data_i,
    input  logic               fifo_valid_i,
    output logic               fifo_ready_o,
    output logic [7:0]         tx_counter_o,
    output logic               tx_counter_upd_o,
    output logic [31:0]        tx_data_o,
    output logic               tx_data_valid_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic               underrun_o,
    output logic [LEN_W-1:0]   words_sent_o
);

    typedef enum logic [1:0] {
        IDLE,
        DUMMY,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   words_sent;
    logic [DUMMY_W-1:0] dummy_cnt;
    logic               underrun;
    logic               issue;

    always_ff @(posedge sclk) begin
        if (cs) begin
            state      <= IDLE;
            remaining  <= '0;
            words_sent <= '0;
            dummy_cnt  <= '0;
            underrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && rd_start_i) begin
                remaining  <= rd_len_i;
                dummy_cnt  <= dummy_cycles_i;
                words_sent <= '0;
            end
            if (state == DUMMY && dummy_cnt != '0) begin
                dummy_cnt <= dummy_cnt - DUMMY_W'(1);
            end
            if (issue) begin
                remaining  <= remaining - LEN_W'(1);
                words_sent <= words_sent + LEN_W'(1);
                if (!fifo_valid_i) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    // A word is issued in the same cycle the shifter reports its last bit,
    // so the next load lands exactly when the previous word finishes.
    always_comb begin
        state_next       = state;
        issue            = 1'b0;
        fifo_ready_o     = 1'b0;
        tx_counter_upd_o = 1'b0;
        tx_data_valid_o  = 1'b0;
        tx_data_o        = '0;
        case (state)
            IDLE: begin
                if (rd_start_i && rd_len_i != '0) begin
                    state_next = DUMMY;
                end
            end
            DUMMY: begin
                if (dummy_cnt == '0) begin
                    issue      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tx_done_i) begin
                    if (remaining != '0) begin
                        issue = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (cs) begin
            issue = 1'b0;
        end
        if (issue) begin
            tx_counter_upd_o = 1'b1;
            tx_data_valid_o  = 1'b1;
            if (fifo_valid_i) begin
                tx_data_o    = fifo_data_i;
                fifo_ready_o = 1'b1;
            end else begin
                tx_data_o = UNDERRUN_WORD;
            end
        end
    end

    assign tx_counter_o = 8'd31;
    assign busy_o       = (state != IDLE);
    assign underrun_o   = underrun;
    assign words_sent_o = words_sent;

endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// Bench for spi_slave_tx_feeder: FIFO and 32-bit shifter models around the DUT,
// expected word issues queued by the stimulus and matched by a negedge monitor.
module tb_spi_slave_tx_feeder;

    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        rd_start = 1'b0;
    logic [15:0] rd_len = '0;
    logic [7:0]  dummy = '0;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [7:0]  tx_counter;
    logic        tx_upd;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_done;
    logic        busy;
    logic        underrun;
    logic [15:0] words_sent;

    spi_slave_tx_feeder dut (
        .sclk            (sclk),
        .cs              (cs),
        .rd_start_i      (rd_start),
        .rd_len_i        (rd_len),
        .dummy_cycles_i  (dummy),
        .fifo_data_i     (fifo_data),
        .fifo_valid_i    (fifo_valid),
        .fifo_ready_o    (fifo_ready),
        .tx_counter_o    (tx_counter),
        .tx_counter_upd_o(tx_upd),
        .tx_data_o       (tx_data),
        .tx_data_valid_o (tx_valid),
        .tx_done_i       (tx_done),
        .busy_o          (busy),
        .underrun_o      (underrun),
        .words_sent_o    (words_sent)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c0 = 0;
    int ready_pulses = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data FIFO model.
    logic [31:0] fifo_mem [0:15];
    int fifo_wr = 0;
    int fifo_rd = 0;
    assign fifo_valid = (fifo_wr != fifo_rd);
    assign fifo_data  = fifo_mem[fifo_rd[3:0]];

    always @(posedge sclk) begin
        if (!cs && fifo_ready && fifo_valid) fifo_rd <= fifo_rd + 1;
    end

    task automatic pushFifo(input logic [31:0] w);
        fifo_mem[fifo_wr[3:0]] = w;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic flushFifo();
        fifo_wr = fifo_rd;
    endtask

    // Shifter model: load on tx_valid, MSB first, last bit flagged by tx_done.
    logic [31:0] sh = '0;
    logic [4:0]  sh_cnt = '0;
    logic        sh_active = 1'b0;
    bit          serial_q[$];
    int          first_bit_cyc = 0;
    int          last_bit_cyc = 0;
    assign tx_done = sh_active && (sh_cnt == 5'd0);

    always @(posedge sclk) begin
        if (cs) begin
            sh_active <= 1'b0;
        end else begin
            if (sh_active) begin
                if (serial_q.size() == 0) first_bit_cyc = cyc;
                serial_q.push_back(sh[31]);
                last_bit_cyc = cyc;
            end
            if (tx_valid) begin
                sh        <= tx_data;
                sh_cnt    <= 5'd31;
                sh_active <= 1'b1;
            end else if (sh_active) begin
                sh <= sh << 1;
                if (sh_cnt == 5'd0) sh_active <= 1'b0;
                else sh_cnt <= sh_cnt - 5'd1;
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int          rel;
        logic        pop;
    } exp_t;
    exp_t sb_q[$];

    task automatic expectIssue(input logic [31:0] d, input int rel, input logic pop);
        exp_t e;
        e.data = d;
        e.rel  = rel;
        e.pop  = pop;
        sb_q.push_back(e);
    endtask

    // Monitor: every issue must match the head of the expected queue.
    always @(negedge sclk) begin
        exp_t e;
        if (!cs) begin
            if (tx_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_issue", 128'(cyc - c0 + 1), 128'(0));
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("issue_data", 128'(tx_data), 128'(e.data));
                    checkOutput("issue_cycle", 128'(cyc - c0 + 1), 128'(e.rel));
                    checkOutput("issue_pop", 128'(fifo_ready), 128'(e.pop));
                    checkOutput("issue_upd", 128'(tx_upd), 128'(1));
                    checkOutput("counter", 128'(tx_counter), 128'(31));
                end
            end else begin
                checkOutput("idle_strobes", 128'({tx_upd, fifo_ready}), 128'(0));
                checkOutput("idle_data", 128'(tx_data), 128'(0));
            end
            if (fifo_ready && !fifo_valid) checkOutput("pop_empty", 128'(1), 128'(0));
            if (fifo_ready) ready_pulses++;
        end
    end

    task automatic pulseStart(input logic [15:0] len, input logic [7:0] dmy);
        @(negedge sclk);
        rd_start = 1'b1;
        rd_len   = len;
        dummy    = dmy;
        @(posedge sclk);
        #1;
        rd_start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] len, input logic [7:0] dmy);
        pulseStart(len, dmy);
        c0 = cyc;
    endtask

    task automatic waitIdle(output int rel);
        bit seen = 0;
        rel = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge sclk);
            #1;
            if (!busy) begin
                seen = 1;
                rel  = cyc - c0;
            end
        end
        if (!seen) checkOutput("idle_timeout", 128'(0), 128'(1));
    endtask

    task automatic checkStream(input string name, input logic [127:0] exp, input int nbits);
        logic [127:0] s = '0;
        foreach (serial_q[i]) s = {s[126:0], serial_q[i]};
        checkOutput({name, "_bits"}, 128'(serial_q.size()), 128'(nbits));
        checkOutput(name, s, exp);
        checkOutput({name, "_gapless"}, 128'(last_bit_cyc - first_bit_cyc), 128'(nbits - 1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rel;
        int p0;

        // Reset then idle: nothing may move.
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        cs = 1'b0;
        repeat (20) @(posedge sclk);
        #1;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_underrun", 128'(underrun), 128'(0));
        checkOutput("rst_words", 128'(words_sent), 128'(0));
        checkOutput("rst_strobes", 128'({tx_upd, tx_valid, fifo_ready}), 128'(0));
        checkOutput("rst_counter", 128'(tx_counter), 128'(31));

        // Three words back-to-back, no dummy cycles.
        flushFifo();
        pushFifo(32'h1111_1111);
        pushFifo(32'h2222_2222);
        pushFifo(32'h3333_3333);
        serial_q.delete();
        p0 = ready_pulses;
        expectIssue(32'h1111_1111, 1, 1'b1);
        expectIssue(32'h2222_2222, 33, 1'b1);
        expectIssue(32'h3333_3333, 65, 1'b1);
        applyStimulus(16'd3, 8'd0);
        checkOutput("t2_busy_start", 128'(busy), 128'(1));
        waitIdle(rel);
        checkOutput("t2_busy_drop", 128'(rel), 128'(97));
        checkOutput("t2_words", 128'(words_sent), 128'(3));
        checkOutput("t2_underrun", 128'(underrun), 128'(0));
        checkOutput("t2_pops", 128'(ready_pulses - p0), 128'(3));
        checkOutput("t2_sb_empty", 128'(sb_q.size()), 128'(0));
        checkStream("t2_stream", {32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 96);
        repeat (3) @(posedge sclk);

        // One word after eight dummy cycles.
        flushFifo();
        pushFifo(32'hCAFE_F00D);
        p0 = ready_pulses;
        expectIssue(32'hCAFE_F00D, 9, 1'b1);
        applyStimulus(16'd1, 8'd8);
        waitIdle(rel);
        checkOutput("t3_busy_drop", 128'(rel), 128'(41));
        checkOutput("t3_pops", 128'(ready_pulses - p0), 128'(1));
        checkOutput("t3_words", 128'(words_sent), 128'(1));
        checkOutput("t3_sb_empty", 128'(sb_q.size()), 128'(0));
        repeat (3) @(posedge sclk);

        // Underrun: second word replaced by the pattern word.
        flushFifo();
        pushFifo(32'hA5A5_A5A5);
        serial_q.delete();
        p0 = ready_pulses;
        expectIssue(32'hA5A5_A5A5, 1, 1'b1);
        expectIssue(32'hDEAD_BEEF, 33, 1'b0);
        applyStimulus(16'd2, 8'd0);
        waitIdle(rel);
        checkOutput("t4_busy_drop", 128'(rel), 128'(65));
        checkOutput("t4_underrun", 128'(underrun), 128'(1));
        checkOutput("t4_pops", 128'(ready_pulses - p0), 128'(1));
        checkOutput("t4_words", 128'(words_sent), 128'(2));
        checkStream("t4_stream", {64'h0, 32'hA5A5_A5A5, 32'hDEAD_BEEF}, 64);
        repeat (5) @(posedge sclk);
        #1;
        checkOutput("t4_underrun_sticky", 128'(underrun), 128'(1));
        @(negedge sclk);
        cs = 1'b1;
        @(posedge sclk);
        #1;
        checkOutput("t4_underrun_cleared", 128'(underrun), 128'(0));
        @(negedge sclk);
        cs = 1'b0;
        repeat (2) @(posedge sclk);

        // Abort by cs mid-transfer; a second start while busy is ignored.
        flushFifo();
        pushFifo(32'h4444_4444);
        pushFifo(32'h5555_5555);
        pushFifo(32'h6666_6666);
        pushFifo(32'h7777_7777);
        p0 = ready_pulses;
        expectIssue(32'h4444_4444, 1, 1'b1);
        expectIssue(32'h5555_5555, 33, 1'b1);
        applyStimulus(16'd4, 8'd0);
        repeat (9) @(posedge sclk);
        pulseStart(16'd1, 8'd0);
        while (cyc - c0 < 40) @(posedge sclk);
        #1;
        checkOutput("t5_words_before_cs", 128'(words_sent), 128'(2));
        checkOutput("t5_busy_before_cs", 128'(busy), 128'(1));
        @(negedge sclk);
        cs = 1'b1;
        @(posedge sclk);
        #1;
        checkOutput("t5_busy_after_cs", 128'(busy), 128'(0));
        checkOutput("t5_words_after_cs", 128'(words_sent), 128'(0));
        @(negedge sclk);
        cs = 1'b0;
        repeat (40) @(posedge sclk);
        #1;
        checkOutput("t5_pops", 128'(ready_pulses - p0), 128'(2));
        checkOutput("t5_sb_empty", 128'(sb_q.size()), 128'(0));
        checkOutput("t5_busy_idle", 128'(busy), 128'(0));

        // Zero-length read, then a normal single-word read.
        flushFifo();
        applyStimulus(16'd0, 8'd0);
        checkOutput("t6_zero_busy", 128'(busy), 128'(0));
        repeat (10) @(posedge sclk);
        #1;
        checkOutput("t6_zero_busy_later", 128'(busy), 128'(0));
        checkOutput("t6_zero_words", 128'(words_sent), 128'(0));
        pushFifo(32'h0BAD_C0DE);
        expectIssue(32'h0BAD_C0DE, 3, 1'b1);
        applyStimulus(16'd1, 8'd2);
        waitIdle(rel);
        checkOutput("t6_busy_drop", 128'(rel), 128'(35));
        checkOutput("t6_words", 128'(words_sent), 128'(1));
        checkOutput("t6_sb_empty", 128'(sb_q.size()), 128'(0));
        repeat (3) @(posedge sclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
